encoder_input_conditioner: RTL and testbench

//  Front end for the rotary-encoder time-set path. Synchronises and debounces the raw encoder A/B and push-switch pins.

---
 rtl/encoder_input_conditioner_if.sv | 47 ++++
 rtl/encoder_input_conditioner.sv | 182 ++++++++++++++++++
 tb/tb_encoder_input_conditioner.sv | 277 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/encoder_input_conditioner_if.sv
`default_nettype none
// ============================================================================
// Module      : encoder_input_conditioner_if
// Description : Bundles the raw rotary-encoder pins and the conditioned
//               outputs that pass between the pin front end and the
//               digit-select/inc-dec stage.
//   i_Encoder_A_Raw        raw channel A, idle high
//   i_Encoder_B_Raw        raw channel B, idle high
//   i_Encoder_Switch_Raw   raw push switch, 0 = pressed
//   o_Encoder_A_Pulse      one-cycle pulse per selected debounced A edge
//   o_Encoder_B_Debounced  debounced B level (direction qualifier)
//   o_Encoder_Enable       set-mode enable, toggled by a long press
//   o_Encoder_Change_Mode  one-cycle pulse on a short-press release
//   modport master : drives the raw pins, observes the outputs
//   modport slave  : the conditioner itself
// Revision    : 1.0 - initial release
// ============================================================================
interface encoder_input_conditioner_if;
    logic i_Encoder_A_Raw;
    logic i_Encoder_B_Raw;
    logic i_Encoder_Switch_Raw;
    logic o_Encoder_A_Pulse;
    logic o_Encoder_B_Debounced;
    logic o_Encoder_Enable;
    logic o_Encoder_Change_Mode;

    modport master (
        output i_Encoder_A_Raw,
        output i_Encoder_B_Raw,
        output i_Encoder_Switch_Raw,
        input  o_Encoder_A_Pulse,
        input  o_Encoder_B_Debounced,
        input  o_Encoder_Enable,
        input  o_Encoder_Change_Mode
    );

    modport slave (
        input  i_Encoder_A_Raw,
        input  i_Encoder_B_Raw,
        input  i_Encoder_Switch_Raw,
        output o_Encoder_A_Pulse,
        output o_Encoder_B_Debounced,
        output o_Encoder_Enable,
        output o_Encoder_Change_Mode
    );
endinterface
`default_nettype wire

// File: rtl/encoder_input_conditioner.sv
`default_nettype none
// ============================================================================
// Module      : encoder_input_conditioner
// Description : Front end for the rotary-encoder time-set path. Each raw pin
//               (A, B, push switch) is synchronised by two flops and then
//               debounced. Debounced A produces a one-cycle edge pulse,
//               debounced B is passed out as the direction qualifier, and
//               the debounced switch drives a press FSM that toggles the
//               set-mode enable on a long press and emits a change-mode
//               pulse on a short-press release while enabled.
// Ports       :
//   i_Clk      in   system clock
//   i_Reset_n  in   asynchronous, active-low reset
//   enc        slave modport of encoder_input_conditioner_if (raw pins in,
//              A pulse / B level / enable / change-mode out)
// Revision    : 1.0 - initial release
// ============================================================================
module encoder_input_conditioner #(
    parameter int DEBOUNCE_LIMIT   = 250000,
    parameter int DEBOUNCE_WIDTH   = 18,
    parameter int LONG_PRESS_LIMIT = 25000000,
    parameter int LONG_PRESS_WIDTH = 25,
    parameter int A_PULSE_EDGE     = 0
) (
    input  wire logic                  i_Clk,
    input  wire logic                  i_Reset_n,
    encoder_input_conditioner_if.slave enc
);

    localparam int c_NUM_CH = 3;
    localparam int c_CH_A   = 0;
    localparam int c_CH_B   = 1;
    localparam int c_CH_SW  = 2;

    localparam logic [DEBOUNCE_WIDTH-1:0]   c_DEB_MAX  = DEBOUNCE_WIDTH'(DEBOUNCE_LIMIT - 1);
    localparam logic [LONG_PRESS_WIDTH-1:0] c_HOLD_MAX = LONG_PRESS_WIDTH'(LONG_PRESS_LIMIT - 1);

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_PRESSED   = 2'd1,
        ST_LONG_HELD = 2'd2
    } state_t;

    // ------------------------------------------------------------------
    // Synchroniser and debouncer, one lane per pin
    // ------------------------------------------------------------------
    logic [c_NUM_CH-1:0]       w_raw;
    logic [c_NUM_CH-1:0]       r_sync1;
    logic [c_NUM_CH-1:0]       r_sync2;
    logic [c_NUM_CH-1:0]       r_deb;
    logic [DEBOUNCE_WIDTH-1:0] r_dcnt [c_NUM_CH];

    assign w_raw = {enc.i_Encoder_Switch_Raw, enc.i_Encoder_B_Raw, enc.i_Encoder_A_Raw};

    // The debounced level only moves after c_DEB_MAX+1 consecutive samples
    // disagree with it; a single agreeing sample restarts the count.
    always_ff @(posedge i_Clk or negedge i_Reset_n) begin
        if (!i_Reset_n) begin
            r_sync1 <= '1;
            r_sync2 <= '1;
            r_deb   <= '1;
            for (int ch = 0; ch < c_NUM_CH; ch++) begin
                r_dcnt[ch] <= '0;
            end
        end else begin
            r_sync1 <= w_raw;
            r_sync2 <= r_sync1;
            for (int ch = 0; ch < c_NUM_CH; ch++) begin
                if (r_sync2[ch] == r_deb[ch]) begin
                    r_dcnt[ch] <= '0;
                end else if (r_dcnt[ch] == c_DEB_MAX) begin
                    r_deb[ch]  <= r_sync2[ch];
                    r_dcnt[ch] <= '0;
                end else begin
                    r_dcnt[ch] <= r_dcnt[ch] + DEBOUNCE_WIDTH'(1);
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // A edge pulse: compares debounced A with its previous value, so the
    // pulse lands one cycle after the debounced level moves. B is already
    // settled by then if it changed on the same edge as A.
    // ------------------------------------------------------------------
    logic r_deb_a_prev;
    logic r_a_pulse;
    logic w_a_edge;

    always_comb begin
        if (A_PULSE_EDGE != 0) begin
            w_a_edge = r_deb[c_CH_A] & ~r_deb_a_prev;
        end else begin
            w_a_edge = ~r_deb[c_CH_A] & r_deb_a_prev;
        end
    end

    always_ff @(posedge i_Clk or negedge i_Reset_n) begin
        if (!i_Reset_n) begin
            r_deb_a_prev <= 1'b1;
            r_a_pulse    <= 1'b0;
        end else begin
            r_deb_a_prev <= r_deb[c_CH_A];
            r_a_pulse    <= w_a_edge;
        end
    end

    // ------------------------------------------------------------------
    // Switch press FSM
    // ------------------------------------------------------------------
    state_t                      r_state;
    state_t                      w_state_next;
    logic [LONG_PRESS_WIDTH-1:0] r_hcnt;
    logic [LONG_PRESS_WIDTH-1:0] w_hcnt_next;
    logic                        r_enable;
    logic                        w_enable_next;
    logic                        r_change_mode;
    logic                        w_change_mode_next;
    logic                        w_sw_pressed;

    assign w_sw_pressed = ~r_deb[c_CH_SW];

    always_ff @(posedge i_Clk or negedge i_Reset_n) begin
        if (!i_Reset_n) begin
            r_state       <= ST_IDLE;
            r_hcnt        <= '0;
            r_enable      <= 1'b0;
            r_change_mode <= 1'b0;
        end else begin
            r_state       <= w_state_next;
            r_hcnt        <= w_hcnt_next;
            r_enable      <= w_enable_next;
            r_change_mode <= w_change_mode_next;
        end
    end

    // Once a press has toggled the enable it parks in LONG_HELD, so the
    // eventual release can never be mistaken for a short press.
    always_comb begin
        w_state_next       = r_state;
        w_hcnt_next        = r_hcnt;
        w_enable_next      = r_enable;
        w_change_mode_next = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_sw_pressed) begin
                    w_state_next = ST_PRESSED;
                    w_hcnt_next  = '0;
                end
            end
            ST_PRESSED: begin
                if (!w_sw_pressed) begin
                    w_state_next       = ST_IDLE;
                    w_change_mode_next = r_enable;
                end else if (r_hcnt == c_HOLD_MAX) begin
                    w_state_next  = ST_LONG_HELD;
                    w_enable_next = ~r_enable;
                end else begin
                    w_hcnt_next = r_hcnt + LONG_PRESS_WIDTH'(1);
                end
            end
            ST_LONG_HELD: begin
                if (!w_sw_pressed) begin
                    w_state_next = ST_IDLE;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Outputs (all straight from flops)
    // ------------------------------------------------------------------
    assign enc.o_Encoder_A_Pulse     = r_a_pulse;
    assign enc.o_Encoder_B_Debounced = r_deb[c_CH_B];
    assign enc.o_Encoder_Enable      = r_enable;
    assign enc.o_Encoder_Change_Mode = r_change_mode;

endmodule
`default_nettype wire

// File: tb/tb_encoder_input_conditioner.sv
`default_nettype none
// ============================================================================
// Module      : tb_encoder_input_conditioner
// Description : Self-checking bench for encoder_input_conditioner with a
//               short debounce (4) and long press (20). Covers reset values,
//               a table of pin patterns with expected pulse counts and
//               levels, exact latency of the A pulse and the enable toggle,
//               reset during a hold, and random pin activity compared every
//               cycle against a reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_encoder_input_conditioner;

    localparam int DL  = 4;
    localparam int DW  = 3;
    localparam int LPL = 20;
    localparam int LPW = 5;
    localparam int HL  = DL + 2;
    localparam int NVEC = 19;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    encoder_input_conditioner_if bus ();

    encoder_input_conditioner #(
        .DEBOUNCE_LIMIT   (DL),
        .DEBOUNCE_WIDTH   (DW),
        .LONG_PRESS_LIMIT (LPL),
        .LONG_PRESS_WIDTH (LPW),
        .A_PULSE_EDGE     (0)
    ) dut (
        .i_Clk     (clk),
        .i_Reset_n (rst_n),
        .enc       (bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic set_pins(input logic a, input logic b, input logic sw);
        bus.i_Encoder_A_Raw      = a;
        bus.i_Encoder_B_Raw      = b;
        bus.i_Encoder_Switch_Raw = sw;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // ------------------------------------------------------------------
    // Reference model: a pin level is accepted once the last DL
    // synchronised samples (pin values from 2..DL+1 edges ago) all differ
    // from the current debounced level. The switch is judged by how many
    // consecutive edges the debounced switch has been low.
    // ------------------------------------------------------------------
    bit m_hist [3][HL];
    bit m_deb  [3];
    bit m_pulse, m_fell, m_en, m_change;
    int m_low_run;

    task automatic model_reset();
        for (int c = 0; c < 3; c++) begin
            for (int i = 0; i < HL; i++) m_hist[c][i] = 1'b1;
            m_deb[c] = 1'b1;
        end
        m_pulse   = 1'b0;
        m_fell    = 1'b0;
        m_en      = 1'b0;
        m_change  = 1'b0;
        m_low_run = 0;
    endtask

    task automatic model_step(input bit pa, input bit pb, input bit psw);
        bit pins [3];
        bit all_diff;
        pins[0] = pa;
        pins[1] = pb;
        pins[2] = psw;
        m_change = 1'b0;
        if (!m_deb[2]) begin
            m_low_run++;
            if (m_low_run == LPL + 1) m_en = !m_en;
        end else begin
            if (m_low_run >= 1 && m_low_run <= LPL && m_en) m_change = 1'b1;
            m_low_run = 0;
        end
        m_pulse = m_fell;
        m_fell  = 1'b0;
        for (int c = 0; c < 3; c++) begin
            for (int i = HL - 1; i > 0; i--) m_hist[c][i] = m_hist[c][i-1];
            m_hist[c][0] = pins[c];
            all_diff = 1'b1;
            for (int i = 2; i <= DL + 1; i++) begin
                if (m_hist[c][i] == m_deb[c]) all_diff = 1'b0;
            end
            if (all_diff) begin
                m_deb[c] = !m_deb[c];
                if (c == 0 && !m_deb[c]) m_fell = 1'b1;
            end
        end
    endtask

    // ------------------------------------------------------------------
    // Vector table: pins held for 'cycles' edges; counts of pulses seen
    // in that window and levels at its end. exp_bp = B level when the
    // A pulse is seen (-1: not checked).
    // ------------------------------------------------------------------
    typedef struct {
        logic a;
        logic b;
        logic sw;
        int   cycles;
        int   exp_pulses;
        int   exp_bp;
        logic exp_b;
        logic exp_en;
        int   exp_changes;
    } vec_t;

    vec_t vecs [NVEC];

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin : main
        int pulses, changes, bp, en_seen;
        int hold [3];
        bit lvl [3];

        vecs[0]  = '{1'b0, 1'b1, 1'b1,  3, 0, -1, 1'b1, 1'b0, 0};
        vecs[1]  = '{1'b1, 1'b1, 1'b1, 10, 0, -1, 1'b1, 1'b0, 0};
        vecs[2]  = '{1'b0, 1'b1, 1'b1, 10, 1,  1, 1'b1, 1'b0, 0};
        vecs[3]  = '{1'b1, 1'b1, 1'b1, 10, 0, -1, 1'b1, 1'b0, 0};
        vecs[4]  = '{1'b1, 1'b0, 1'b1, 10, 0, -1, 1'b0, 1'b0, 0};
        vecs[5]  = '{1'b0, 1'b0, 1'b1, 10, 1,  0, 1'b0, 1'b0, 0};
        vecs[6]  = '{1'b1, 1'b1, 1'b1, 10, 0, -1, 1'b1, 1'b0, 0};
        vecs[7]  = '{1'b0, 1'b1, 1'b1, 10, 1,  1, 1'b1, 1'b0, 0};
        vecs[8]  = '{1'b1, 1'b0, 1'b1, 10, 0, -1, 1'b0, 1'b0, 0};
        vecs[9]  = '{1'b0, 1'b1, 1'b1, 10, 1,  1, 1'b1, 1'b0, 0};
        vecs[10] = '{1'b1, 1'b1, 1'b1, 10, 0, -1, 1'b1, 1'b0, 0};
        vecs[11] = '{1'b1, 1'b1, 1'b0, 30, 0, -1, 1'b1, 1'b1, 0};
        vecs[12] = '{1'b1, 1'b1, 1'b1, 10, 0, -1, 1'b1, 1'b1, 0};
        vecs[13] = '{1'b1, 1'b1, 1'b0, 10, 0, -1, 1'b1, 1'b1, 0};
        vecs[14] = '{1'b1, 1'b1, 1'b1, 10, 0, -1, 1'b1, 1'b1, 1};
        vecs[15] = '{1'b1, 1'b1, 1'b0, 30, 0, -1, 1'b1, 1'b0, 0};
        vecs[16] = '{1'b1, 1'b1, 1'b1, 10, 0, -1, 1'b1, 1'b0, 0};
        vecs[17] = '{1'b1, 1'b1, 1'b0, 10, 0, -1, 1'b1, 1'b0, 0};
        vecs[18] = '{1'b1, 1'b1, 1'b1, 10, 0, -1, 1'b1, 1'b0, 0};

        // Reset values
        set_pins(1'b1, 1'b1, 1'b1);
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_a_pulse", int'(bus.o_Encoder_A_Pulse), 0);
        check("reset_b_deb",   int'(bus.o_Encoder_B_Debounced), 1);
        check("reset_enable",  int'(bus.o_Encoder_Enable), 0);
        check("reset_change",  int'(bus.o_Encoder_Change_Mode), 0);
        rst_n = 1'b1;

        // A pulse latency: pin falls, pulse exactly after the 7th edge
        bus.i_Encoder_A_Raw = 1'b0;
        for (int i = 1; i <= 9; i++) begin
            step();
            check($sformatf("a_latency_edge%0d", i), int'(bus.o_Encoder_A_Pulse), (i == 2 + DL + 1) ? 1 : 0);
        end
        bus.i_Encoder_A_Raw = 1'b1;
        repeat (10) step();

        // Table-driven vectors
        do_reset();
        for (int r = 0; r < NVEC; r++) begin
            set_pins(vecs[r].a, vecs[r].b, vecs[r].sw);
            pulses  = 0;
            changes = 0;
            bp      = -1;
            for (int i = 0; i < vecs[r].cycles; i++) begin
                step();
                if (bus.o_Encoder_A_Pulse) begin
                    pulses++;
                    bp = int'(bus.o_Encoder_B_Debounced);
                end
                if (bus.o_Encoder_Change_Mode) changes++;
            end
            check($sformatf("row%0d_pulses", r),  pulses,  vecs[r].exp_pulses);
            check($sformatf("row%0d_changes", r), changes, vecs[r].exp_changes);
            check($sformatf("row%0d_b_deb", r),   int'(bus.o_Encoder_B_Debounced), int'(vecs[r].exp_b));
            check($sformatf("row%0d_enable", r),  int'(bus.o_Encoder_Enable), int'(vecs[r].exp_en));
            if (vecs[r].exp_bp >= 0) check($sformatf("row%0d_b_at_pulse", r), bp, vecs[r].exp_bp);
        end

        // Exact long-press timing: deb low after 6 edges, PRESSED on the
        // 7th, toggle 20 edges later on the 27th.
        bus.i_Encoder_Switch_Raw = 1'b0;
        for (int i = 1; i <= 30; i++) begin
            step();
            check($sformatf("long_en_edge%0d", i), int'(bus.o_Encoder_Enable), (i >= 2 + DL + 1 + LPL) ? 1 : 0);
        end
        bus.i_Encoder_Switch_Raw = 1'b1;
        repeat (10) step();

        // Reset while held: hcnt reaches 15 on edge 22 of the press
        bus.i_Encoder_Switch_Raw = 1'b0;
        repeat (22) step();
        check("hold_pre_reset_en", int'(bus.o_Encoder_Enable), 1);
        rst_n = 1'b0;
        repeat (3) step();
        check("hold_reset_en",     int'(bus.o_Encoder_Enable), 0);
        check("hold_reset_change", int'(bus.o_Encoder_Change_Mode), 0);
        rst_n = 1'b1;
        repeat (2) step();
        bus.i_Encoder_Switch_Raw = 1'b1;
        changes = 0;
        en_seen = 0;
        for (int i = 0; i < 15; i++) begin
            step();
            if (bus.o_Encoder_Change_Mode) changes++;
            if (bus.o_Encoder_Enable) en_seen++;
        end
        check("hold_after_changes", changes, 0);
        check("hold_after_enable",  en_seen, 0);

        // Random pin activity against the reference model
        set_pins(1'b1, 1'b1, 1'b1);
        do_reset();
        model_reset();
        for (int c = 0; c < 3; c++) begin
            hold[c] = 0;
            lvl[c]  = 1'b1;
        end
        for (int cyc = 0; cyc < 3000; cyc++) begin
            for (int c = 0; c < 3; c++) begin
                if (hold[c] == 0) begin
                    lvl[c]  = bit'($urandom_range(0, 1));
                    hold[c] = (c == 2) ? int'($urandom_range(1, 45)) : int'($urandom_range(1, 9));
                end
                hold[c]--;
            end
            set_pins(lvl[0], lvl[1], lvl[2]);
            @(posedge clk);
            model_step(lvl[0], lvl[1], lvl[2]);
            @(negedge clk);
            check($sformatf("rand%0d_a_pulse", cyc), int'(bus.o_Encoder_A_Pulse), int'(m_pulse));
            check($sformatf("rand%0d_b_deb", cyc),   int'(bus.o_Encoder_B_Debounced), int'(m_deb[1]));
            check($sformatf("rand%0d_enable", cyc),  int'(bus.o_Encoder_Enable), int'(m_en));
            check($sformatf("rand%0d_change", cyc),  int'(bus.o_Encoder_Change_Mode), int'(m_change));
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
